// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_ext_s.sv
// Load lane select and sign/zero extension. Half lanes use only a[1], so a
// misaligned half or word silently reads the aligned lane.
module load_ext_s
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  byte_l;
    logic [15:0] half_l;

    always_comb begin
        byte_l = rdata[8*a +: 8];
        half_l = a[1] ? rdata[31:16] : rdata[15:0];
        unique case (funct3)
            F3_B:    ext = {{24{byte_l[7]}}, byte_l};
            F3_BU:   ext = {24'h0, byte_l};
            F3_H:    ext = {{16{half_l[15]}}, half_l};
            F3_HU:   ext = {16'h0, half_l};
            F3_W:    ext = rdata;
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_s.sv
// MEM stage: drives the valid/grant/rvalid data bus, stalls while an access is
// outstanding and registers the MEM/WB boundary. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage_s
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_isValid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_instr,
    input  logic [4:0]  mem_rd,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_sData,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        wb_isValid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_instr,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_result,
    output logic        wb_bus_err,
    output logic        wb_misalign
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]  funct3;
    logic [1:0]  a;
    logic        access, is_load, is_store, sz_byte, sz_half, sz_word;
    logic        misalign, bus_access, timeout;
    logic        req, stall, complete, bus_err;
    logic [3:0]  strb;
    logic [31:0] wdata, load_data;

    assign funct3   = mem_instr[14:12];
    assign a        = mem_result[1:0];
    assign access   = mem_isValid & (mem_mem_read | mem_mem_write);
    assign is_load  = mem_mem_read;
    assign is_store = mem_mem_write & ~mem_mem_read;
    // Unsigned byte/half codes only exist for loads; anything else is a word.
    assign sz_byte  = (funct3 == F3_B) | (is_load & (funct3 == F3_BU));
    assign sz_half  = (funct3 == F3_H) | (is_load & (funct3 == F3_HU));
    assign sz_word  = ~sz_byte & ~sz_half;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access & ((sz_half & a[0]) | (sz_word & (a != 2'b00)));
`else
    assign misalign = 1'b0;
`endif
    assign bus_access = access & ~misalign;
    assign timeout    = (cnt_q == TO_LAST);

    always_comb begin
        strb  = 4'b1111;
        wdata = mem_sData;
        if (sz_byte) begin
            strb  = 4'b0001 << a;
            wdata = {4{mem_sData[7:0]}};
        end else if (sz_half) begin
            strb  = a[1] ? 4'b1100 : 4'b0011;
            wdata = {2{mem_sData[15:0]}};
        end
    end

    load_ext_s u_load_ext (
        .rdata  (dm_rdata),
        .a      (a),
        .funct3 (funct3),
        .ext    (load_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        bus_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_isValid) begin
                    if (!bus_access) begin
                        complete = 1'b1;
                    end else begin
                        req   = 1'b1;
                        cnt_d = '0;
                        if (dm_gnt && !is_load) begin
                            complete = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = dm_gnt ? RESP : REQ;
                        end
                    end
                end
            end
            REQ: begin
                req   = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (dm_gnt && !is_load) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timeout) begin
                    complete = 1'b1;
                    bus_err  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                    if (dm_gnt) state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (dm_rvalid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timeout) begin
                    complete = 1'b1;
                    bus_err  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dm_req    = req & ~reset;
    assign mem_stall = stall & ~reset;
    assign dm_we     = bus_access & is_store & ~reset;
    assign dm_addr   = reset ? 32'h0 : {mem_result[31:2], 2'b00};
    assign dm_wstrb  = dm_we ? strb : 4'b0000;
    assign dm_wdata  = dm_we ? wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wb_isValid   <= 1'b0;
            wb_pc        <= 32'h0;
            wb_instr     <= 32'h0;
            wb_rd        <= 5'h0;
            wb_reg_write <= 1'b0;
            wb_result    <= 32'h0;
            wb_bus_err   <= 1'b0;
            wb_misalign  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (complete) begin
                wb_isValid   <= 1'b1;
                wb_pc        <= mem_pc;
                wb_instr     <= mem_instr;
                wb_rd        <= mem_rd;
                wb_reg_write <= mem_reg_write & ~bus_err & ~misalign;
                wb_result    <= (bus_access && is_load && !bus_err) ? load_data : mem_result;
                wb_bus_err   <= bus_err;
                wb_misalign  <= misalign;
            end else begin
                wb_isValid   <= 1'b0;
                wb_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_s.sv
// Self-checking bench for mem_stage_s with a byte-lane reference model.
module tb_mem_stage_s;

    localparam int unsigned TO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_isValid, mem_mem_read, mem_mem_write, mem_reg_write;
    logic [31:0] mem_pc, mem_instr, mem_result, mem_sData;
    logic [4:0]  mem_rd;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid, mem_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        wb_isValid, wb_reg_write, wb_bus_err, wb_misalign;
    logic [31:0] wb_pc, wb_instr, wb_result;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_s #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .mem_isValid(mem_isValid), .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_rd(mem_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_result(mem_result), .mem_sData(mem_sData),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .wb_bus_err(wb_bus_err), .wb_misalign(wb_misalign)
    );

    function automatic int acc_size(input logic [2:0] f3, input bit is_load);
        if (f3 == 3'd0 || (is_load && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (is_load && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input logic [31:0] addr, input int size);
        return TRAP && ((int'(addr[1:0]) % size) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int size = acc_size(f3, 1'b1);
        int base = int'(addr[1:0]) / size * size;
        logic [31:0] v;
        if (size == 4) return w;
        v = (w >> (8 * base)) & ((size == 1) ? 32'hFF : 32'hFFFF);
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] addr, input int size);
        int base = int'(addr[1:0]) / size * size;
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + size);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int size);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(d >> (8 * (i % size)));
        return w;
    endfunction

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'h0, op};
    endfunction

    // Presents one instruction and plays the bus side; gdel = grant delay,
    // rdel = rvalid delay after grant (-1: never).
    task automatic run_access(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, input logic rd_op, input logic wr_op,
                              input logic regw, input logic [31:0] res,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int gdel, input int rdel, output int stalls,
                              output logic req_seen, output logic we_seen,
                              output logic [31:0] addr_seen, output logic [3:0] strb_seen,
                              output logic [31:0] wdata_seen);
        bit granted = 1'b0;
        bit done = 1'b0;
        int gk = 0;
        mem_isValid = 1'b1; mem_pc = pc; mem_instr = instr; mem_rd = rd;
        mem_mem_read = rd_op; mem_mem_write = wr_op; mem_reg_write = regw;
        mem_result = res; mem_sData = sdata; dm_rdata = rdata;
        stalls = 0; req_seen = 1'b0; we_seen = 1'b0;
        addr_seen = 32'h0; strb_seen = 4'h0; wdata_seen = 32'h0;
        for (int k = 0; k < 40 && !done; k++) begin
            dm_gnt    = !granted && (k >= gdel);
            dm_rvalid = granted && (rdel >= 0) && (k >= gk + 1 + rdel);
            #3;
            if (dm_req && !req_seen) begin
                req_seen = 1'b1; we_seen = dm_we; addr_seen = dm_addr;
                strb_seen = dm_wstrb; wdata_seen = dm_wdata;
            end
            if (dm_req && dm_gnt) begin
                granted = 1'b1; gk = k;
            end
            if (mem_stall) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        mem_isValid = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL run_access_bound: stall still high after 40 cycles, required completion");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_isValid = 1'b1; mem_mem_read = 1'b1; mem_mem_write = 1'b0;
        mem_reg_write = 1'b1; mem_pc = 32'h40; mem_instr = mk_instr(3'd2, 7'h03);
        mem_rd = 5'd3; mem_result = 32'h100; mem_sData = 32'h0;
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(posedge clk); @(posedge clk); #4;
        n_checks++;
        if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: dm_req=%b mem_stall=%b, required 0 0", dm_req, mem_stall);
        end
        n_checks++;
        if ({wb_isValid, wb_reg_write, wb_bus_err, wb_misalign} !== 4'b0 ||
            wb_result !== 32'h0 || wb_pc !== 32'h0 || wb_rd !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_wb: valid=%b rw=%b err=%b mis=%b res=%h, required all 0",
                     wb_isValid, wb_reg_write, wb_bus_err, wb_misalign, wb_result);
        end
        mem_isValid = 1'b0; mem_mem_read = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        run_access(32'h200, 32'h0000_0033, 5'd5, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 32'h0,
                   0, 0, st, rq, we, ad, sb, wd);
        n_checks++;
        if (wb_isValid !== 1'b1 || wb_result !== 32'h1234 || wb_rd !== 5'd5 ||
            wb_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL add_wb: valid=%b res=%h rd=%0d rw=%b, required 1 00001234 5 1",
                     wb_isValid, wb_result, wb_rd, wb_reg_write);
        end
        n_checks++;
        if (st != 0 || rq !== 1'b0) begin
            n_fail++;
            $display("FAIL add_stall: stalls=%0d req=%b, required 0 0", st, rq);
        end
        #3;
        @(posedge clk); #1;
        n_checks++;
        if (wb_isValid !== 1'b0 || wb_reg_write !== 1'b0 || wb_result !== 32'h1234) begin
            n_fail++;
            $display("FAIL bubble_wb: valid=%b rw=%b res=%h, required 0 0 00001234",
                     wb_isValid, wb_reg_write, wb_result);
        end
    endtask

    task automatic test_load_byte();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        logic [31:0] exp_res [2];
        logic [2:0]  f3s [2];
        exp_res[0] = 32'hFFFF_FF80; exp_res[1] = 32'h0000_0080;
        f3s[0] = 3'd0; f3s[1] = 3'd4;
        for (int i = 0; i < 2; i++) begin
            run_access(32'h300 + 32'(4 * i), mk_instr(f3s[i], 7'h03), 5'd7, 1'b1, 1'b0, 1'b1,
                       32'h103, 32'h0, 32'h80FF_7F01, 0, 0, st, rq, we, ad, sb, wd);
            n_checks++;
            if (wb_result !== exp_res[i] || wb_isValid !== 1'b1 || wb_reg_write !== 1'b1) begin
                n_fail++;
                $display("FAIL lb_result[%0d]: res=%h valid=%b rw=%b, required %h 1 1",
                         i, wb_result, wb_isValid, wb_reg_write, exp_res[i]);
            end
            n_checks++;
            if (ad !== 32'h100 || st != 1 || we !== 1'b0 || sb !== 4'h0) begin
                n_fail++;
                $display("FAIL lb_bus[%0d]: addr=%h stalls=%0d we=%b strb=%b, required 100 1 0 0",
                         i, ad, st, we, sb);
            end
        end
    endtask

    task automatic test_store_half();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        run_access(32'h400, mk_instr(3'd1, 7'h23), 5'd0, 1'b0, 1'b1, 1'b0, 32'h202,
                   32'hABCD_1234, 32'h0, 3, 0, st, rq, we, ad, sb, wd);
        n_checks++;
        if (sb !== 4'b1100 || wd !== 32'h1234_1234 || we !== 1'b1 || ad !== 32'h200) begin
            n_fail++;
            $display("FAIL sh_bus: strb=%b wdata=%h we=%b addr=%h, required 1100 12341234 1 200",
                     sb, wd, we, ad);
        end
        n_checks++;
        if (st != 3 || wb_reg_write !== 1'b0 || wb_isValid !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_wb: stalls=%0d rw=%b valid=%b, required 3 0 1",
                     st, wb_reg_write, wb_isValid);
        end
    endtask

    task automatic test_timeout();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        run_access(32'h500, mk_instr(3'd2, 7'h03), 5'd9, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0,
                   32'h5555_AAAA, 0, -1, st, rq, we, ad, sb, wd);
        n_checks++;
        if (wb_bus_err !== 1'b1 || wb_reg_write !== 1'b0 || wb_isValid !== 1'b1 ||
            st != int'(TO)) begin
            n_fail++;
            $display("FAIL timeout_wb: err=%b rw=%b valid=%b stalls=%0d, required 1 0 1 %0d",
                     wb_bus_err, wb_reg_write, wb_isValid, st, TO);
        end
        dm_rvalid = 1'b1; dm_rdata = 32'h1111_2222;
        #3;
        n_checks++;
        if (mem_stall !== 1'b0 || dm_req !== 1'b0) begin
            n_fail++;
            $display("FAIL late_rvalid_comb: stall=%b req=%b, required 0 0", mem_stall, dm_req);
        end
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
        n_checks++;
        if (wb_isValid !== 1'b0 || wb_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL late_rvalid_wb: valid=%b rw=%b, required 0 0", wb_isValid, wb_reg_write);
        end
        run_access(32'h504, mk_instr(3'd2, 7'h03), 5'd9, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0,
                   32'hCAFE_F00D, 1, 1, st, rq, we, ad, sb, wd);
        n_checks++;
        if (wb_result !== 32'hCAFE_F00D || wb_bus_err !== 1'b0 || st != 3) begin
            n_fail++;
            $display("FAIL after_timeout_lw: res=%h err=%b stalls=%0d, required cafef00d 0 3",
                     wb_result, wb_bus_err, st);
        end
    endtask

    task automatic test_reset_mid();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        mem_isValid = 1'b1; mem_pc = 32'h600; mem_instr = mk_instr(3'd2, 7'h03);
        mem_rd = 5'd4; mem_mem_read = 1'b1; mem_mem_write = 1'b0; mem_reg_write = 1'b1;
        mem_result = 32'h80; dm_gnt = 1'b1; dm_rvalid = 1'b0;
        @(posedge clk); #1;
        dm_gnt = 1'b0; reset = 1'b1;
        #3;
        n_checks++;
        if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_comb: req=%b stall=%b, required 0 0", dm_req, mem_stall);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_isValid = 1'b0; mem_mem_read = 1'b0;
        n_checks++;
        if ({wb_isValid, wb_reg_write, wb_bus_err, wb_misalign} !== 4'b0 ||
            wb_result !== 32'h0 || wb_pc !== 32'h0 || wb_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wb: valid=%b rw=%b err=%b res=%h pc=%h, required all 0",
                     wb_isValid, wb_reg_write, wb_bus_err, wb_result, wb_pc);
        end
        run_access(32'h604, mk_instr(3'd5, 7'h03), 5'd6, 1'b1, 1'b0, 1'b1, 32'h86, 32'h0,
                   32'h9876_5432, 0, 0, st, rq, we, ad, sb, wd);
        n_checks++;
        if (wb_result !== 32'h0000_9876 || st != 1 || wb_pc !== 32'h604) begin
            n_fail++;
            $display("FAIL post_reset_lhu: res=%h stalls=%0d pc=%h, required 00009876 1 604",
                     wb_result, st, wb_pc);
        end
    endtask

    task automatic test_lw_misaligned();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        run_access(32'h700, mk_instr(3'd2, 7'h03), 5'd8, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0,
                   32'hDEAD_BEEF, 0, 0, st, rq, we, ad, sb, wd);
        n_checks++;
        if (TRAP) begin
            if (rq !== 1'b0 || wb_misalign !== 1'b1 || wb_reg_write !== 1'b0 || st != 0) begin
                n_fail++;
                $display("FAIL lw_trap: req=%b mis=%b rw=%b stalls=%0d, required 0 1 0 0",
                         rq, wb_misalign, wb_reg_write, st);
            end
        end else begin
            if (ad !== 32'h100 || wb_result !== 32'hDEAD_BEEF || wb_misalign !== 1'b0 ||
                st != 1) begin
                n_fail++;
                $display("FAIL lw_noalign: addr=%h res=%h mis=%b stalls=%0d, required 100 deadbeef 0 1",
                         ad, wb_result, wb_misalign, st);
            end
        end
    endtask

    task automatic test_random();
        int st; logic rq, we; logic [31:0] ad, wd; logic [3:0] sb;
        for (int it = 0; it < 40; it++) begin
            int kind = int'($urandom_range(0, 2));
            bit ld = (kind == 1);
            bit str = (kind == 2);
            logic [2:0] f3 = str ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic [31:0] sdata = $urandom;
            logic [31:0] rdata = $urandom;
            logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
            logic regw = str ? 1'b0 : (ld ? 1'b1 : 1'($urandom_range(0, 1)));
            int size = acc_size(f3, ld);
            bit mis = (ld || str) && model_mis(addr, size);
            int gdel = int'($urandom_range(0, str ? 3 : 2));
            int rdel = int'($urandom_range(0, 2 - ((gdel > 2) ? 2 : gdel)));
            int exp_st = (!(ld || str) || mis) ? 0 : (str ? gdel : gdel + 1 + rdel);
            logic [31:0] exp_res = (ld && !mis) ? model_load(rdata, addr, f3) : addr;
            run_access(pc, mk_instr(f3, ld ? 7'h03 : (str ? 7'h23 : 7'h13)), 5'(it), ld, str,
                       regw, addr, sdata, rdata, gdel, rdel, st, rq, we, ad, sb, wd);
            n_checks++;
            if (wb_result !== exp_res || wb_isValid !== 1'b1 || wb_pc !== pc ||
                wb_reg_write !== (regw & !mis) || wb_misalign !== 1'(mis) || st != exp_st) begin
                n_fail++;
                $display("FAIL rand_wb[%0d]: res=%h rw=%b mis=%b stalls=%0d, required %h %b %b %0d",
                         it, wb_result, wb_reg_write, wb_misalign, st, exp_res, regw & !mis,
                         mis, exp_st);
            end
            if (str && !mis) begin
                n_checks++;
                if (sb !== model_strb(addr, size) || wd !== model_wdata(sdata, size) ||
                    ad !== (addr & 32'hFFFF_FFFC) || we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_store[%0d]: strb=%b wdata=%h addr=%h, required %b %h %h",
                             it, sb, wd, ad, model_strb(addr, size), model_wdata(sdata, size),
                             addr & 32'hFFFF_FFFC);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_byte();
        test_store_half();
        test_timeout();
        test_reset_mid();
        test_lw_misaligned();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
